// File: rtl/hes_decipher_if.sv
// Byte-stream handshake bundle for hes_decipher: ciphertext in, plaintext out.
interface hes_decipher_if;
  logic       valid_in;
  logic       ready_in;
  logic       new_message;
  logic [7:0] key;
  logic [7:0] data_in;
  logic       valid_out;
  logic       ready_out;
  logic [7:0] data_out;
  logic       wrap_err;

  modport master (
    output valid_in, new_message, key, data_in, ready_out,
    input  ready_in, valid_out, data_out, wrap_err
  );

  modport slave (
    input  valid_in, new_message, key, data_in, ready_out,
    output ready_in, valid_out, data_out, wrap_err
  );
endinterface

// File: rtl/hes_decipher.sv
// AES-S-box counter-mode byte decipher: stage-1 register plus 3-entry output FIFO.
// Optional HES_DECIPHER_DBG_EN exposes the keystream counter on counter_block.
module hes_decipher (
  input  logic          clk,
  input  logic          reset,
  hes_decipher_if.slave bus
`ifdef HES_DECIPHER_DBG_EN
  ,
  output logic [7:0]    counter_block
`endif
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic [7:0] ctr_q, ctr_d, key_q, key_d;
  logic       wrap_q, wrap_d;
  logic       s1_valid_q, s1_valid_d;
  logic [7:0] s1_data_q, s1_data_d, s1_ks_q, s1_ks_d;
  logic [7:0] fifo_q [3];
  logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt_q, cnt_d;
  logic [2:0] occupancy;
  logic       accept, push, pop;
  logic [7:0] ks;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign occupancy     = {2'b00, s1_valid_q} + {1'b0, cnt_q};
  assign bus.ready_in  = ~reset & (occupancy < 3'd4);
  assign bus.valid_out = ~reset & (cnt_q != 2'd0);
  assign bus.data_out  = bus.valid_out ? fifo_q[rd_ptr_q] : '0;
  assign bus.wrap_err  = ~reset & wrap_q;

  assign accept = bus.valid_in & bus.ready_in;
  assign pop    = bus.valid_out & bus.ready_out;
  // Stage 1 may drain into a full FIFO only when the head leaves on the same edge.
  assign push   = s1_valid_q & ((cnt_q != 2'd3) | pop);
  // A coincident new_message forces ctr=0, so the S-box index is the fresh key itself.
  assign ks     = SBOX[bus.new_message ? bus.key : (ctr_q ^ key_q)];

`ifdef HES_DECIPHER_DBG_EN
  assign counter_block = ctr_q;
`endif

  always_comb begin
    ctr_d      = ctr_q;
    key_d      = key_q;
    wrap_d     = wrap_q;
    s1_valid_d = accept | (s1_valid_q & ~push);
    s1_data_d  = s1_data_q;
    s1_ks_d    = s1_ks_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;

    if (bus.new_message) begin
      key_d  = bus.key;
      ctr_d  = accept ? 8'h01 : 8'h00;
      wrap_d = 1'b0;
    end else if (accept) begin
      ctr_d = ctr_q + 8'h01;
      if (ctr_q == 8'hFF) wrap_d = 1'b1;
    end

    if (accept) begin
      s1_data_d = bus.data_in;
      s1_ks_d   = ks;
    end

    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctr_q      <= '0;
      key_q      <= '0;
      wrap_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_ks_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      ctr_q      <= ctr_d;
      key_q      <= key_d;
      wrap_q     <= wrap_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_ks_q    <= s1_ks_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) fifo_q[wr_ptr_q] <= s1_data_q ^ s1_ks_q;
  end

endmodule

// File: tb/tb_hes_decipher.sv
// Scoreboard bench for hes_decipher; reference S-box derived from GF(2^8) inverse + affine map.
module tb_hes_decipher;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hes_decipher_if bus ();
`ifdef HES_DECIPHER_DBG_EN
  logic [7:0] counter_block;
  hes_decipher dut (.clk(clk), .reset(reset), .bus(bus.slave), .counter_block(counter_block));
`else
  hes_decipher dut (.clk(clk), .reset(reset), .bus(bus.slave));
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] sbox_ref [256];
  logic [7:0] exp_q [$];
  logic [7:0] m_ctr, m_key;
  logic       m_wrap;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_ref[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  end

  // Reference model: sees each transfer at the negedge before the edge that commits it.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_ctr = 8'h00; m_key = 8'h00; m_wrap = 1'b0;
    end else begin
      logic acc;
      logic [7:0] c, k;
      chk("wrap_err", {7'b0, bus.wrap_err}, {7'b0, m_wrap});
`ifdef HES_DECIPHER_DBG_EN
      chk("counter_block", counter_block, m_ctr);
`endif
      acc = bus.valid_in && bus.ready_in;
      c = bus.new_message ? 8'h00 : m_ctr;
      k = bus.new_message ? bus.key : m_key;
      if (acc) exp_q.push_back(bus.data_in ^ sbox_ref[c ^ k]);
      if (bus.new_message) begin
        m_key = bus.key; m_ctr = acc ? 8'h01 : 8'h00; m_wrap = 1'b0;
      end else if (acc) begin
        if (m_ctr == 8'hFF) m_wrap = 1'b1;
        m_ctr = m_ctr + 8'h01;
      end
    end
  end

  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  always @(negedge clk) begin
    if (!reset && bus.valid_out) begin
      if (prev_stall) chk("hold_stable", bus.data_out, prev_data);
      if (bus.ready_out) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out: got %h expected no output at %0t", bus.data_out, $time);
        end else begin
          chk("data_out", bus.data_out, exp_q.pop_front());
        end
      end
      prev_stall = !bus.ready_out;
      prev_data  = bus.data_out;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] d, input logic nm, input logic [7:0] k);
    int  w = 0;
    bit  done = 0;
    bus.valid_in = 1'b1; bus.data_in = d; bus.new_message = nm; bus.key = k;
    while (!done) begin
      @(negedge clk);
      if (bus.ready_in) done = 1;
      tick();
      bus.new_message = 1'b0;
      if (done) bus.valid_in = 1'b0;
      else if (++w > 100) begin
        chk("send_timeout", 8'd0, 8'd1);
        bus.valid_in = 1'b0; done = 1;
      end
    end
  endtask

  task automatic pulse_nm(input logic [7:0] k);
    bus.new_message = 1'b1; bus.key = k;
    tick();
    bus.new_message = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    bus.ready_out = 1'b1;
    while ((exp_q.size() != 0 || bus.valid_out) && w < 200) begin tick(); w++; end
    if (w >= 200) chk("drain_timeout", 8'd0, 8'd1);
    tick();
  endtask

  initial begin
    int n, guard, outs;
    bit stall;
    reset = 1'b1;
    bus.valid_in = 1'b0; bus.new_message = 1'b0; bus.key = 8'h00;
    bus.data_in = 8'h00; bus.ready_out = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready_in", {7'b0, bus.ready_in}, 8'd0);
    chk("rst_valid_out", {7'b0, bus.valid_out}, 8'd0);
    chk("rst_data_out", bus.data_out, 8'h00);
    chk("rst_wrap_err", {7'b0, bus.wrap_err}, 8'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready_in", {7'b0, bus.ready_in}, 8'd1);
    tick();

    // Basic stream with key 0x11 and stage latency
    pulse_nm(8'h11);
    send(8'h00, 1'b0, 8'h00);
    @(negedge clk);
    chk("lat_E", {7'b0, bus.valid_out}, 8'd0);
    @(negedge clk);
    chk("lat_E1", {7'b0, bus.valid_out}, 8'd1);
    chk("first_0x82", bus.data_out, 8'h82);
    tick();
    send(8'h00, 1'b0, 8'h00);
    wait_drain();

    // Byte coincident with new_message
    send(8'h41, 1'b1, 8'h11);
    send(8'hDA, 1'b0, 8'h00);
    wait_drain();

    // Backpressure: capacity 4
    bus.ready_out = 1'b0;
    tick();
    n = 0;
    bus.valid_in = 1'b1; bus.data_in = 8'hA0;
    repeat (10) begin
      @(negedge clk);
      if (bus.ready_in) n++;
      tick();
      bus.data_in = 8'hA0 + 8'(n);
    end
    chk("cap_accepts", 8'(n), 8'd4);
    @(negedge clk);
    chk("cap_ready_low", {7'b0, bus.ready_in}, 8'd0);
    tick();
    bus.ready_out = 1'b1;
    @(negedge clk);
    chk("ready_before_pop", {7'b0, bus.ready_in}, 8'd0);
    tick();
    @(negedge clk);
    chk("ready_after_pop", {7'b0, bus.ready_in}, 8'd1);
    if (bus.ready_in) n++;
    tick();
    bus.data_in = 8'hA0 + 8'(n);
    guard = 0;
    while (n < 6 && guard < 50) begin
      @(negedge clk);
      if (bus.ready_in) n++;
      tick();
      bus.data_in = 8'hA0 + 8'(n);
      guard++;
    end
    bus.valid_in = 1'b0;
    chk("cap_total", 8'(n), 8'd6);
    wait_drain();

    // Counter wrap over 257 bytes
    pulse_nm(8'h00);
    for (int i = 1; i <= 257; i++) begin
      send(8'h00, 1'b0, 8'h00);
      if (i == 255 || i == 256) begin
        @(negedge clk);
        chk("wrap_at_accept", {7'b0, bus.wrap_err}, (i == 256) ? 8'd1 : 8'd0);
        tick();
      end
    end
    wait_drain();
    pulse_nm(8'h00);
    @(negedge clk);
    chk("wrap_cleared", {7'b0, bus.wrap_err}, 8'd0);
    tick();

    // Key change while a byte sits in stage 1
    pulse_nm(8'h11);
    send(8'h5A, 1'b0, 8'h00);
    send(8'h00, 1'b0, 8'h00);
    pulse_nm(8'h00);
    send(8'h00, 1'b0, 8'h00);
    wait_drain();

    // Random traffic
    bus.valid_in = 1'b0;
    repeat (800) begin
      @(negedge clk);
      stall = bus.valid_in && !bus.ready_in;
      tick();
      if (!stall) begin
        bus.valid_in = ($urandom_range(0, 3) != 0);
        bus.data_in  = 8'($urandom);
      end
      bus.new_message = ($urandom_range(0, 15) == 0);
      bus.key         = 8'($urandom);
      bus.ready_out   = ($urandom_range(0, 2) != 0);
    end
    bus.valid_in = 1'b0; bus.new_message = 1'b0;
    wait_drain();

    // Reset with bytes buffered
    bus.ready_out = 1'b0;
    pulse_nm(8'h3C);
    send(8'h01, 1'b0, 8'h00);
    send(8'h02, 1'b0, 8'h00);
    send(8'h03, 1'b0, 8'h00);
    repeat (3) tick();
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid_out", {7'b0, bus.valid_out}, 8'd0);
    tick();
    @(negedge clk);
    chk("after_rst_edge_valid", {7'b0, bus.valid_out}, 8'd0);
    tick();
    reset = 1'b0;
    bus.ready_out = 1'b1;
    outs = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.valid_out) outs++;
      tick();
    end
    chk("no_stale_out", 8'(outs), 8'd0);

    chk("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
